// File: rtl/mult_sequencer_if.sv
// Core-side handshake for the shift-add multiplier: request/operands in, product and status out.
// The core drives the master modport; mult_sequencer takes the slave modport.
interface mult_sequencer_if #(
  parameter int WL = 32
);
  logic          start;
  logic          signed_mul;
  logic [WL-1:0] src_a;
  logic [WL-1:0] src_b;
  logic [WL-1:0] hi;
  logic [WL-1:0] lo;
  logic          busy;
  logic          done;

  modport master (
    output start, signed_mul, src_a, src_b,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, signed_mul, src_a, src_b,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mult_sequencer.sv
// Shift-add MULT/MULTU sequencer driving one shared (WL+1)-bit external adder for WL iterations.
// Define MULT_SIGNED_EN to enable signed MULT (magnitude operands plus a one-cycle sign-fix state).
//
// state  | meaning
// IDLE   | waiting for start; adder inputs held at zero
// RUN    | one shift-add iteration per cycle using the shared adder
// FIX    | signed build only: negate {acc,q} when the result sign is negative
// DONE   | done pulse, product on hi/lo; a new start may be accepted here
module mult_sequencer #(
  parameter int WL = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mult_sequencer_if.slave     s_bus,
  input  logic [WL:0]         i_adder_sum,
  output logic [WL:0]         o_adder_a,
  output logic [WL:0]         o_adder_b
);

  localparam int CW = (WL > 1) ? $clog2(WL) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic [WL-1:0] r_acc;
  logic [WL-1:0] r_q;
  logic [WL-1:0] r_m;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [WL-1:0] w_m_load;
  logic [WL-1:0] w_q_load;
  logic          w_last;

`ifdef MULT_SIGNED_EN
  logic          r_neg_res;
  logic          w_neg_a;
  logic          w_neg_b;
  logic [2*WL-1:0] w_neg_prod;

  // The most negative operand negates to itself, which read unsigned is exactly 2^(WL-1).
  assign w_neg_a    = s_bus.signed_mul & s_bus.src_a[WL-1];
  assign w_neg_b    = s_bus.signed_mul & s_bus.src_b[WL-1];
  assign w_m_load   = w_neg_a ? (~s_bus.src_a + 1'b1) : s_bus.src_a;
  assign w_q_load   = w_neg_b ? (~s_bus.src_b + 1'b1) : s_bus.src_b;
  assign w_neg_prod = ~{r_acc, r_q} + 1'b1;
`else
  logic          w_unused_signed;

  assign w_unused_signed = s_bus.signed_mul;
  assign w_m_load        = s_bus.src_a;
  assign w_q_load        = s_bus.src_b;
`endif

  assign w_last = (r_cnt == CW'(WL-1));

  always_comb begin
    o_adder_a = '0;
    o_adder_b = '0;
    if (r_state == S_RUN) begin
      o_adder_a = {1'b0, r_acc};
      o_adder_b = r_q[0] ? {1'b0, r_m} : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef MULT_SIGNED_EN
      r_neg_res <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (s_bus.start) begin
            r_acc     <= '0;
            r_q       <= w_q_load;
            r_m       <= w_m_load;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_RUN;
`ifdef MULT_SIGNED_EN
            r_neg_res <= w_neg_a ^ w_neg_b;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc <= i_adder_sum[WL:1];
          r_q   <= {i_adder_sum[0], r_q[WL-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
`ifdef MULT_SIGNED_EN
            r_state <= S_FIX;
`else
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
`endif
          end
        end
`ifdef MULT_SIGNED_EN
        // Taken unconditionally so signed and unsigned requests share one latency.
        S_FIX: begin
          if (r_neg_res) begin
            {r_acc, r_q} <= w_neg_prod;
          end
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign s_bus.hi   = r_acc;
  assign s_bus.lo   = r_q;
  assign s_bus.busy = r_busy;
  assign s_bus.done = r_done;

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: stimulus pushes hand-computed products, a monitor pops on done.
// Expected values follow MULT_SIGNED_EN when it is defined for the build.
module tb_mult_sequencer;
  localparam int WL = 32;
`ifdef MULT_SIGNED_EN
  localparam int EXP_BUSY = WL + 1;
`else
  localparam int EXP_BUSY = WL;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [WL:0] adder_a;
  logic [WL:0] adder_b;
  logic [WL:0] adder_sum;

  mult_sequencer_if #(.WL(WL)) bus ();

  mult_sequencer #(.WL(WL)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .s_bus       (bus),
    .i_adder_sum (adder_sum),
    .o_adder_a   (adder_a),
    .o_adder_b   (adder_b)
  );

  // Stand-in for the shared Adder #(.WL(WL+1)).
  assign adder_sum = adder_a + adder_b;

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [2*WL-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected product per done pulse; also checks idle adder inputs.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_done: got done with hi=%0h lo=%0h, required no done", bus.hi, bus.lo);
        end else begin
          check("product", {64'd0, bus.hi, bus.lo}, {64'd0, exp_q.pop_front()});
          check("busy_in_done", {127'd0, bus.busy}, 128'd0);
        end
      end
      if (!bus.busy)
        check("adder_idle", {62'd0, adder_a, adder_b}, 128'd0);
    end
  end

  // Drive at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input logic [WL-1:0] a, input logic [WL-1:0] b, input logic s,
                       input logic push, input logic [2*WL-1:0] exp);
    bus.start      = 1'b1;
    bus.src_a      = a;
    bus.src_b      = b;
    bus.signed_mul = s;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    bus.start = 1'b0;
    bus.src_a = '1;
    bus.src_b = '1;
  endtask

  task automatic wait_done(output int busy_cycles);
    bit seen;
    seen = 0;
    busy_cycles = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done) begin
        seen = 1;
        break;
      end
      if (bus.busy) busy_cycles++;
      @(negedge clk);
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done in 200 cycles, required done");
    end
  endtask

  task automatic run(input logic [WL-1:0] a, input logic [WL-1:0] b, input logic s,
                     input logic [2*WL-1:0] exp, input string name);
    int bc;
    issue(a, b, s, 1'b1, exp);
    wait_done(bc);
    check(name, bc, EXP_BUSY);
    @(negedge clk);
  endtask

  initial begin
    int bc;
    bus.start      = 1'b1;
    bus.signed_mul = 1'b0;
    bus.src_a      = 32'd3;
    bus.src_b      = 32'd5;
    rst            = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", {127'd0, bus.busy}, 128'd0);
    check("reset_done", {127'd0, bus.done}, 128'd0);
    check("reset_hilo", {64'd0, bus.hi, bus.lo}, 128'd0);
    check("reset_adders", {62'd0, adder_a, adder_b}, 128'd0);
    bus.start = 1'b0;
    rst       = 1'b0;
    repeat (2) @(negedge clk);

    // Basic and boundary vectors.
    run(32'd3, 32'd5, 1'b0, 64'h00000000_0000000F, "busy_3x5");
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, "busy_max");
`ifdef MULT_SIGNED_EN
    run(32'hFFFFFFFE, 32'd3, 1'b1, 64'hFFFFFFFF_FFFFFFFA, "busy_neg2x3");
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001, "busy_m1xm1");
    run(32'h80000000, 32'd1, 1'b1, 64'hFFFFFFFF_80000000, "busy_minx1");
    run(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, "busy_minxmin");
`else
    run(32'hFFFFFFFE, 32'd3, 1'b1, 64'h00000002_FFFFFFFA, "busy_neg2x3");
`endif
    run(32'h80000000, 32'd2, 1'b0, 64'h00000001_00000000, "busy_msb_x2");
    run(32'h00010000, 32'h00010000, 1'b0, 64'h00000001_00000000, "busy_2p16sq");
    run(32'd0, 32'h12345678, 1'b0, 64'd0, "busy_zero");

    // Start during a run is ignored.
    issue(32'd7, 32'd9, 1'b0, 1'b1, 64'd63);
    repeat (4) @(negedge clk);
    issue(32'd100, 32'd100, 1'b0, 1'b0, 64'd0);
    wait_done(bc);
    repeat (5) @(negedge clk);

    // Reset mid-run aborts with no done.
    issue(32'd11, 32'd13, 1'b0, 1'b0, 64'd0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {127'd0, bus.busy}, 128'd0);
    check("abort_hilo", {64'd0, bus.hi, bus.lo}, 128'd0);
    check("abort_done", {127'd0, bus.done}, 128'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run(32'd6, 32'd7, 1'b0, 64'd42, "busy_after_abort");

    // Back-to-back: new start in the done cycle.
    issue(32'd3, 32'd5, 1'b0, 1'b1, 64'd15);
    wait_done(bc);
    check("b2b_hilo_held", {64'd0, bus.hi, bus.lo}, 128'h0F);
    issue(32'd7, 32'd6, 1'b0, 1'b1, 64'h2A);
    check("b2b_busy_next", {127'd0, bus.busy}, 128'd1);
    wait_done(bc);
    check("b2b_busy_count", bc, EXP_BUSY);
    repeat (5) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
